// File: rtl/port_req_collector_pkg.sv
// Shared constants for the request collector and its serializer neighbour.
package port_req_collector_pkg;

  // Number of independent memory ports feeding one bundle.
  localparam int unsigned NumPorts     = 3;
  // Default request payload width, matched by the serializer.
  localparam int unsigned DefaultWidth = 8;

  // Pointer width for a FIFO of the given depth; a depth of 1 still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/port_req_fifo.sv
// Small synchronous FIFO holding pending requests for one memory port.
module port_req_fifo
  import port_req_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full       = (count_q == CntW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when it pops at the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & head_valid;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/port_req_collector.sv
// Collects requests from three ports and presents a registered, gap-free bundle.
module port_req_collector
  import port_req_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] p1_data,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [WIDTH-1:0] p2_data,
  input  logic             p2_valid,
  output logic             p2_ready,
  input  logic [WIDTH-1:0] p3_data,
  input  logic             p3_valid,
  output logic             p3_ready,
  input  logic             freeze_inputs,
  output logic [WIDTH-1:0] entry1_data,
  output logic             entry1_valid,
  output logic [WIDTH-1:0] entry2_data,
  output logic             entry2_valid,
  output logic [WIDTH-1:0] entry3_data,
  output logic             entry3_valid
);

  localparam int unsigned SlotW = $clog2(NumPorts + 1);

  logic [WIDTH-1:0]    port_data   [NumPorts];
  logic [WIDTH-1:0]    head_data   [NumPorts];
  logic [NumPorts-1:0] port_valid;
  logic [NumPorts-1:0] port_ready;
  logic [NumPorts-1:0] head_valid;
  logic [NumPorts-1:0] fifo_full;
  logic                alive_q;

  logic [WIDTH-1:0]    slot_data_d [NumPorts];
  logic [WIDTH-1:0]    slot_data_q [NumPorts];
  logic [NumPorts-1:0] slot_valid_d, slot_valid_q;
  logic [SlotW-1:0]    fill;

  assign port_data[0] = p1_data;
  assign port_data[1] = p2_data;
  assign port_data[2] = p3_data;
  assign port_valid   = {p3_valid, p2_valid, p1_valid};

  // Ready depends only on flops, never on the requester's valid.
  assign port_ready = {NumPorts{alive_q}} & ~fifo_full;
  assign p1_ready   = port_ready[0];
  assign p2_ready   = port_ready[1];
  assign p3_ready   = port_ready[2];

  for (genvar i = 0; i < NumPorts; i++) begin : g_fifo
    port_req_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (port_valid[i] & port_ready[i]),
      .push_data (port_data[i]),
      .pop       (~freeze_inputs),
      .head_data (head_data[i]),
      .head_valid(head_valid[i]),
      .full      (fifo_full[i])
    );
  end

  // Ports stay not-ready until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alive_q <= 1'b0;
    else          alive_q <= 1'b1;
  end

  // Pack non-empty heads into the lowest slots in port order; unused slots are zero.
  always_comb begin
    fill         = '0;
    slot_valid_d = '0;
    for (int unsigned s = 0; s < NumPorts; s++) slot_data_d[s] = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (head_valid[i]) begin
        slot_data_d[fill]  = head_data[i];
        slot_valid_d[fill] = 1'b1;
        fill               = fill + SlotW'(1);
      end
    end
  end

  // Bundle register: reloaded on every consume, held while frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_q <= '0;
      for (int unsigned s = 0; s < NumPorts; s++) slot_data_q[s] <= '0;
    end else if (!freeze_inputs) begin
      slot_valid_q <= slot_valid_d;
      for (int unsigned s = 0; s < NumPorts; s++) slot_data_q[s] <= slot_data_d[s];
    end
  end

  assign entry1_data  = slot_data_q[0];
  assign entry1_valid = slot_valid_q[0];
  assign entry2_data  = slot_data_q[1];
  assign entry2_valid = slot_valid_q[1];
  assign entry3_data  = slot_data_q[2];
  assign entry3_valid = slot_valid_q[2];

endmodule
